data_mem_line_ctrl: RTL
=======================

# data_mem_line_ctrl

Parametrised, latency-modelled line memory for the pipeline's data cache. It accepts read-line, write-word and write-line requests over a valid/ready handshake and commits each one after a configurable number of cycles. It returns whole cache lines, or an error flag, over a second valid/ready handshake. It sits between the data cache refill/writeback logic and backing storage, and supports sub-word stores with correct byte-lane placement and range checking.

## Interface
- LINE_SIZE, 4, 32-bit words per cache line; power of two, ≥1
- DEPTH, 512, memory size in 32-bit words; multiple of LINE_SIZE
- LATENCY, 2, cycles from request acceptance to response; ≥1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_op  in  2  00 read line, 01 write word, 10 write line, 11 reserved
- req_funct3  in  3  write-word size: 000 sb, 001 sh, 010 sw
- req_addr  in  32  byte address
- req_wdata  in  32  write-word data, right-aligned (sb uses [7:0], sh uses [15:0])
- req_wline  in  32*LINE_SIZE  write-line data; word i at [32*i +: 32]
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_line  out  32*LINE_SIZE  read-line data; word i at [32*i +: 32]; 0 for writes and errors
- resp_err  out  1  request rejected; no memory change

## Operation
- Storage: DEPTH × 32-bit words. Word index = req_addr[31:2]. Line base = word index with its low log2(LINE_SIZE) bits cleared.
- Request fields are captured on acceptance (req_valid && req_ready). Inputs are ignored at all other times.
- FSM:
  - IDLE → BUSY on acceptance; counter loads LATENCY-1.
  - BUSY: counter decrements. When it reaches 0, the access commits and the state moves to RESP.
  - RESP → IDLE on resp_valid && resp_ready.
- Read line: returns words base..base+LINE_SIZE-1.
- Write word:
  - sb writes byte lane addr[1:0].
  - sh writes halfword lane addr[1]; addr[0] must be 0.
  - sw writes the full word; addr[1:0] must be 00.
  - Unwritten bytes of the target word are preserved.
- Write line: all LINE_SIZE words at the line base are written from req_wline. req_funct3 and addr low bits are ignored.
- Error (resp_err=1, no write, resp_line=0) on any of:
  - word index ≥ DEPTH
  - misaligned sh or sw
  - write-word funct3 not in {000, 001, 010}
  - req_op=11

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_line=0, resp_err=0, counter=0.
- Request accepted at edge N. The commit and the resp_valid rise both occur at edge N+LATENCY.
- Memory writes take effect at the commit edge.
- Read data is sampled from memory at the commit edge, so it reflects all earlier commits.
- resp_valid, resp_line and resp_err stay stable while resp_valid && !resp_ready.
- req_ready is combinational from state==IDLE. Minimum request-to-request spacing is LATENCY+2 cycles when resp_ready is held high.
- A response is held indefinitely under backpressure. No new request is accepted meanwhile.
- Reset mid-operation:
  - FSM returns to IDLE immediately.
  - A pending, uncommitted write is dropped.
  - A pending response is discarded.
- Memory contents under reset depend on DATA_MEM_LINE_CLEAR_EN.

## Configuration
- DATA_MEM_LINE_CLEAR_EN defined: rst asynchronously clears all DEPTH words to 0.
- DATA_MEM_LINE_CLEAR_EN not defined: rst affects control state and outputs only; memory contents are retained across reset.

## Test plan
Configuration: LINE_SIZE=4, DEPTH=512, LATENCY=2, DATA_MEM_LINE_CLEAR_EN defined.
- Reset, then read line at 0x40 → resp_valid 2 cycles after acceptance; resp_line all 0; resp_err=0.
- sw 0xDEADBEEF to 0x14, then read line at 0x10 → word1=0xDEADBEEF; words 0, 2 and 3 = 0.
- sb 0xAB to 0x17 → word 0xABADBEEF. Then sh 0x1234 to 0x14 → 0xABAD1234. Then read line at 0x10 confirms.
- Write line to 0x800 (word 512) → resp_err=1, no write. sw to 0x15 → resp_err=1 and word 0x14 unchanged. req_op=11 → resp_err=1.
- resp_ready held low 5 cycles after a read response → resp_valid/resp_line/resp_err stable and req_ready=0. A new req_valid during this time is not accepted; it is accepted after the handshake.
- Accept sw 0x55 to 0x20, then pulse rst one cycle after acceptance → no response; word 0x20 reads 0 afterwards; req_ready=1 once rst deasserts.

Source files
------------

// File: rtl/data_mem_line_ctrl.sv
// Latency-modelled line memory for the data cache: read-line, write-word
// and write-line requests. Optional macro: DATA_MEM_LINE_CLEAR_EN (reset clears memory).
module data_mem_line_ctrl #(
    parameter int LINE_SIZE = 4,
    parameter int DEPTH     = 512,
    parameter int LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [2:0]                req_funct3,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    input  logic [32*LINE_SIZE-1:0]   req_wline,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [32*LINE_SIZE-1:0]   resp_line,
    output logic                      resp_err
);

    localparam int LW = 32 * LINE_SIZE;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WW = 2'b01;
    localparam logic [1:0] OP_WL = 2'b10;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [AW-1:0] LMASK = AW'(LINE_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [LW-1:0]   wline_q, wline_d;
    logic            resp_valid_q, resp_valid_d;
    logic [LW-1:0]   resp_line_q, resp_line_d;
    logic            resp_err_q, resp_err_d;

    logic [31:0]     mem_q [DEPTH];

    logic            accept;
    logic            commit;
    logic            oob;
    logic            bad_word;
    logic            err_c;
    logic [AW-1:0]   widx;
    logic [AW-1:0]   base;
    logic [LW-1:0]   rd_line;
    logic [3:0]      be;
    logic [31:0]     wd_rep;
    logic [31:0]     merged;
    logic            we_word;
    logic            we_line;

    assign req_ready  = (state_q == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_line  = resp_line_q;
    assign resp_err   = resp_err_q;

    // Capture request fields only on a handshake; hold them otherwise.
    always_comb begin
        op_d    = op_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wline_d = wline_q;
        if (accept) begin
            op_d    = req_op;
            f3_d    = req_funct3;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wline_d = req_wline;
        end
    end

    // Sequencing: IDLE -> BUSY (latency countdown) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Range, alignment and opcode checks on the captured request.
    always_comb begin
        oob      = (addr_q[31:2] >= 30'(DEPTH));
        bad_word = 1'b0;
        unique case (f3_q)
            F3_SB:   bad_word = 1'b0;
            F3_SH:   bad_word = addr_q[0];
            F3_SW:   bad_word = (addr_q[1:0] != 2'b00);
            default: bad_word = 1'b1;
        endcase
        err_c = oob
             || (op_q == 2'b11)
             || ((op_q == OP_WW) && bad_word);
    end

    // Line base and the gathered read line at that base.
    always_comb begin
        widx    = addr_q[AW+1:2];
        base    = widx & ~LMASK;
        rd_line = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            rd_line[32*i +: 32] = mem_q[base + AW'(i)];
        end
    end

    // Sub-word store: replicate data across lanes, enable only target bytes.
    always_comb begin
        be     = 4'b0000;
        wd_rep = wdata_q;
        unique case (f3_q)
            F3_SB: begin
                be     = 4'b0001 << addr_q[1:0];
                wd_rep = {4{wdata_q[7:0]}};
            end
            F3_SH: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wdata_q[15:0]}};
            end
            F3_SW: begin
                be     = 4'b1111;
                wd_rep = wdata_q;
            end
            default: begin
                be     = 4'b0000;
                wd_rep = wdata_q;
            end
        endcase
        merged = mem_q[widx];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wd_rep[8*b +: 8];
            end
        end
        we_word = commit && !err_c && (op_q == OP_WW);
        we_line = commit && !err_c && (op_q == OP_WL);
    end

    // Response registers: load at commit, drop valid on handshake.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_line_d  = resp_line_q;
        resp_err_d   = resp_err_q;
        if (commit) begin
            resp_valid_d = 1'b1;
            resp_err_d   = err_c;
            if ((op_q == OP_RD) && !err_c) begin
                resp_line_d = rd_line;
            end else begin
                resp_line_d = '0;
            end
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Control and response state; reset aborts any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wline_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_line_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wline_q      <= wline_d;
            resp_valid_q <= resp_valid_d;
            resp_line_q  <= resp_line_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef DATA_MEM_LINE_CLEAR_EN
    // Storage array; reset wipes every word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_word) begin
            mem_q[widx] <= merged;
        end else if (we_line) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                mem_q[base + AW'(i)] <= wline_q[32*i +: 32];
            end
        end
    end
`else
    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_word) begin
            mem_q[widx] <= merged;
        end else if (we_line) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                mem_q[base + AW'(i)] <= wline_q[32*i +: 32];
            end
        end
    end
`endif

endmodule
